// File: rtl/alu_writeback_stage.sv
// Writeback stage behind ALU_16bit: a 2-entry result buffer that retires to the accumulator or the shared RF port.
// Optional feature: define STICKY_OVF_EN for a sticky overflow flag that is cleared by ovf_clr.
module alu_writeback_stage #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero,
    input  logic             alu_ovf,
    input  logic [AW-1:0]    dest,
    input  logic             upd_flags,
    output logic             rf_req,
    input  logic             rf_gnt,
    output logic             rf_we,
    output logic [AW-1:0]    rf_waddr,
    output logic [WIDTH-1:0] rf_wdata,
    output logic [WIDTH-1:0] acc,
    output logic             flag_z,
    output logic             flag_v,
    input  logic             ovf_clr,
    output logic             busy
);

    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_data [DEPTH];
    logic [AW-1:0]    r_tag  [DEPTH];
    logic             r_zero [DEPTH];
    logic             r_ovf  [DEPTH];
    logic             r_upd  [DEPTH];
    logic             r_rd;
    logic             r_wr;
    logic [WIDTH-1:0] r_acc;
    logic             r_flag_z;
    logic             r_flag_v;

    logic             w_busy;
    logic             w_head_is_acc;
    logic             w_pop;
    logic             w_push;

    assign w_busy        = (r_state != S_EMPTY);
    assign w_head_is_acc = (r_tag[r_rd] == '0);
    // Accumulator retires unconditionally; RF entries wait for the shared port grant.
    assign w_pop         = w_busy & (w_head_is_acc | rf_gnt);
    assign in_ready      = (r_state != S_TWO) | w_pop;
    assign w_push        = in_valid & in_ready;

    assign busy     = w_busy;
    assign rf_req   = w_busy & ~w_head_is_acc;
    assign rf_we    = rf_req & rf_gnt;
    assign rf_waddr = w_busy ? r_tag[r_rd]  : '0;
    assign rf_wdata = w_busy ? r_data[r_rd] : '0;
    assign acc      = r_acc;
    assign flag_z   = r_flag_z;
    assign flag_v   = r_flag_v;

`ifndef STICKY_OVF_EN
    logic w_unused_ovf_clr;
    assign w_unused_ovf_clr = ovf_clr;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_EMPTY;
            r_rd     <= 1'b0;
            r_wr     <= 1'b0;
            r_acc    <= '0;
            r_flag_z <= 1'b0;
            r_flag_v <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
                r_tag[i]  <= '0;
                r_zero[i] <= 1'b0;
                r_ovf[i]  <= 1'b0;
                r_upd[i]  <= 1'b0;
            end
        end else begin
            if (w_push) begin
                r_data[r_wr] <= alu_out;
                r_tag[r_wr]  <= dest;
                r_zero[r_wr] <= alu_zero;
                r_ovf[r_wr]  <= alu_ovf;
                r_upd[r_wr]  <= upd_flags;
                r_wr         <= ~r_wr;
            end
            if (w_pop) begin
                r_rd <= ~r_rd;
                if (w_head_is_acc) r_acc <= r_data[r_rd];
                if (r_upd[r_rd]) r_flag_z <= r_zero[r_rd];
            end
`ifdef STICKY_OVF_EN
            // Clear takes priority over a same-cycle overflow retire.
            if (ovf_clr)
                r_flag_v <= 1'b0;
            else if (w_pop && r_upd[r_rd])
                r_flag_v <= r_flag_v | r_ovf[r_rd];
`else
            if (w_pop && r_upd[r_rd]) r_flag_v <= r_ovf[r_rd];
`endif
            case (r_state)
                S_EMPTY: if (w_push) r_state <= S_ONE;
                S_ONE: begin
                    if (w_push && !w_pop)      r_state <= S_TWO;
                    else if (w_pop && !w_push) r_state <= S_EMPTY;
                end
                S_TWO:   if (w_pop && !w_push) r_state <= S_ONE;
                default: r_state <= S_EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Testbench for alu_writeback_stage: directed scenarios then random traffic against a queue-based model.
module tb_alu_writeback_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] alu_out;
    logic        alu_zero;
    logic        alu_ovf;
    logic [2:0]  dest;
    logic        upd_flags;
    logic        rf_req;
    logic        rf_gnt;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic [15:0] acc;
    logic        flag_z;
    logic        flag_v;
    logic        ovf_clr;
    logic        busy;

    alu_writeback_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_out(alu_out), .alu_zero(alu_zero), .alu_ovf(alu_ovf), .dest(dest),
        .upd_flags(upd_flags), .rf_req(rf_req), .rf_gnt(rf_gnt), .rf_we(rf_we),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .acc(acc), .flag_z(flag_z),
        .flag_v(flag_v), .ovf_clr(ovf_clr), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] data;
        logic        z;
        logic        o;
        logic [2:0]  tag;
        logic        upd;
    } ent_t;

    ent_t        q[$];
    logic [15:0] m_acc;
    logic        m_z;
    logic        m_v;
    logic        last_accepted;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle at the falling edge, compare against the model, then advance the model.
    task automatic step(input logic v, input logic [15:0] d, input logic z, input logic o,
                        input logic [2:0] t, input logic u, input logic g, input logic c);
        ent_t h;
        logic e_busy, e_req, e_we, e_pop, e_rdy;
        @(negedge clk);
        in_valid = v; alu_out = d; alu_zero = z; alu_ovf = o;
        dest = t; upd_flags = u; rf_gnt = g; ovf_clr = c;
        #1;
        e_busy = (q.size() != 0);
        h      = e_busy ? q[0] : '0;
        e_req  = e_busy && (h.tag != 3'd0);
        e_we   = e_req && g;
        e_pop  = e_busy && (h.tag == 3'd0 || g);
        e_rdy  = (q.size() < 2) || e_pop;
        chk("busy", {31'd0, busy}, {31'd0, e_busy});
        chk("in_ready", {31'd0, in_ready}, {31'd0, e_rdy});
        chk("rf_req", {31'd0, rf_req}, {31'd0, e_req});
        chk("rf_we", {31'd0, rf_we}, {31'd0, e_we});
        chk("rf_waddr", {29'd0, rf_waddr}, {29'd0, h.tag});
        chk("rf_wdata", {16'd0, rf_wdata}, {16'd0, h.data});
        chk("acc", {16'd0, acc}, {16'd0, m_acc});
        chk("flag_z", {31'd0, flag_z}, {31'd0, m_z});
        chk("flag_v", {31'd0, flag_v}, {31'd0, m_v});
        if (e_pop) begin
            if (h.tag == 3'd0) m_acc = h.data;
            if (h.upd) begin
                m_z = h.z;
`ifdef STICKY_OVF_EN
                m_v = m_v | h.o;
`else
                m_v = h.o;
`endif
            end
            void'(q.pop_front());
        end
`ifdef STICKY_OVF_EN
        if (c) m_v = 1'b0;
`endif
        last_accepted = v && e_rdy;
        if (last_accepted) q.push_back('{data: d, z: z, o: o, tag: t, upd: u});
    endtask

    task automatic idle(input logic g);
        step(1'b0, 16'h0, 1'b0, 1'b0, 3'd0, 1'b0, g, 1'b0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        in_valid = 1'b0; rf_gnt = 1'b0; ovf_clr = 1'b0;
        rst_n = 1'b0;
        q.delete();
        m_acc = '0; m_z = 1'b0; m_v = 1'b0;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_rf_req", {31'd0, rf_req}, 32'd0);
        chk("rst_rf_waddr", {29'd0, rf_waddr}, 32'd0);
        chk("rst_rf_wdata", {16'd0, rf_wdata}, 32'd0);
        chk("rst_acc", {16'd0, acc}, 32'd0);
        chk("rst_flags", {30'd0, flag_z, flag_v}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        ent_t pend;
        logic have_pend;
        rst_n = 1'b1; in_valid = 1'b0; alu_out = '0; alu_zero = 1'b0; alu_ovf = 1'b0;
        dest = '0; upd_flags = 1'b0; rf_gnt = 1'b0; ovf_clr = 1'b0;
        m_acc = '0; m_z = 1'b0; m_v = 1'b0; last_accepted = 1'b0;
        apply_reset();

        // Accumulator write.
        step(1'b1, 16'd9, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b0);
        chk("acc_is_9", {16'd0, acc}, 32'd9);

        // RF write held off by missing grant, then granted.
        step(1'b1, 16'h7BCD, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0);
        repeat (3) idle(1'b0);
        chk("hold_waddr", {29'd0, rf_waddr}, 32'd3);
        chk("hold_wdata", {16'd0, rf_wdata}, 32'h7BCD);
        idle(1'b1);
        idle(1'b0);

        // Full buffer back-pressure, third push lands on the grant cycle.
        step(1'b1, 16'h0505, 1'b0, 1'b0, 3'd5, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h0A0A, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h3333, 1'b0, 1'b0, 3'd6, 1'b0, 1'b0, 1'b0);
        chk("full_not_ready", {31'd0, in_ready}, 32'd0);
        step(1'b1, 16'h3333, 1'b0, 1'b0, 3'd6, 1'b0, 1'b1, 1'b0);
        repeat (3) idle(1'b1);
        chk("acc_after_order", {16'd0, acc}, 32'h0A0A);

        // Flag sequence, then overflow clear.
        step(1'b1, 16'h0000, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 16'hFFFF, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 16'h0001, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b0);
`ifdef STICKY_OVF_EN
        chk("flag_v_sticky", {31'd0, flag_v}, 32'd1);
`else
        chk("flag_v_plain", {31'd0, flag_v}, 32'd0);
`endif
        step(1'b0, 16'h0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        chk("flag_v_cleared", {31'd0, flag_v}, 32'd0);

        // upd_flags=0 must not touch flags.
        step(1'b1, 16'h0000, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h1234, 1'b1, 1'b1, 3'd2, 1'b0, 1'b1, 1'b0);
        repeat (2) idle(1'b1);
        chk("noupd_flag_z", {31'd0, flag_z}, 32'd0);

        // Reset mid-run with two entries held.
        step(1'b1, 16'hBEEF, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0);
        step(1'b1, 16'hCAFE, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0);
        apply_reset();
        repeat (3) idle(1'b1);

        // Random traffic; upstream holds a stalled transfer stable.
        have_pend = 1'b0;
        pend = '0;
        for (int i = 0; i < 400; i++) begin
            logic v;
            if (!have_pend) begin
                pend.data = 16'($urandom);
                pend.z    = 1'($urandom);
                pend.o    = 1'($urandom);
                pend.tag  = ($urandom_range(0, 2) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
                pend.upd  = 1'($urandom);
                v = ($urandom_range(0, 3) != 0);
            end else begin
                v = 1'b1;
            end
            step(v, pend.data, pend.z, pend.o, pend.tag, pend.upd,
                 1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0));
            have_pend = v && !last_accepted;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
